// File: rtl/bf16_sub_pipe.sv
// bf16_sub_pipe: three-stage pipelined BF16 subtractor, o_data = a - b.
// Define BF16_SUB_FLAGS_EN to add the {invalid, overflow, underflow} o_flags port.

module bf16_sub_pipe #(
  parameter int SIZE_DATA = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data
`ifdef BF16_SUB_FLAGS_EN
  ,
  output logic [2:0]           o_flags
`endif
);

  typedef struct packed {
    logic        vld;
    logic [15:0] a;
    logic [15:0] b;
  } s1_t;

  typedef struct packed {
    logic        vld;
    logic        spc;
    logic [15:0] spc_data;
`ifdef BF16_SUB_FLAGS_EN
    logic        inv;
`endif
    logic        sign;
    logic        sub;
    logic [7:0]  exp;
    logic [15:0] mx;
    logic [15:0] mn;
  } s2_t;

  typedef struct packed {
    logic        vld;
    logic        spc;
    logic [15:0] spc_data;
`ifdef BF16_SUB_FLAGS_EN
    logic        inv;
`endif
    logic        sign;
    logic [7:0]  exp;
    logic [16:0] sum;
  } s3_t;

  logic adv;
  s1_t  s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;

  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  // S1: capture the operand pair
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '0;
    end else if (adv) begin
      s1_q.vld <= i_valid;
      s1_q.a   <= i_data_a;
      s1_q.b   <= i_data_b;
    end
  end

  logic       sa, sb, sbn;
  logic [7:0] ea, eb;
  logic [6:0] ma, mb;
  logic       za, zb, ia, ib, na, nb;
  logic       a_max;
  logic [7:0] mn_e, mx_e, d;
  logic [6:0] mx_m, mn_m;
  logic       c_nan, c_ii, c_ia, c_ib;
  logic       c_zz, c_bz, c_az;

  assign sa  = s1_q.a[15];
  assign sb  = s1_q.b[15];
  assign sbn = ~sb;
  assign ea  = s1_q.a[14:7];
  assign eb  = s1_q.b[14:7];
  assign ma  = s1_q.a[6:0];
  assign mb  = s1_q.b[6:0];

  assign za = (ea == 8'h00);
  assign zb = (eb == 8'h00);
  assign ia = (ea == 8'hFF) && (ma == 7'h00);
  assign ib = (eb == 8'hFF) && (mb == 7'h00);
  assign na = (ea == 8'hFF) && (ma != 7'h00);
  assign nb = (eb == 8'hFF) && (mb != 7'h00);

  assign c_nan = na | nb;
  assign c_ii  = ia & ib & (sa == sb);
  assign c_ia  = ia & ~nb & ~c_ii;
  assign c_ib  = ib & ~ia & ~na;
  assign c_zz  = za & zb;
  assign c_bz  = zb & ~za & (ea != 8'hFF);
  assign c_az  = za & ~zb & (eb != 8'hFF);

  assign a_max = s1_q.a[14:0] >= s1_q.b[14:0];
  assign mx_e  = a_max ? ea : eb;
  assign mn_e  = a_max ? eb : ea;
  assign mx_m  = a_max ? ma : mb;
  assign mn_m  = a_max ? mb : ma;
  assign d     = mx_e - mn_e;

  // Align: order by magnitude, shift the smaller, resolve specials
  always_comb begin
    s2_d      = '0;
    s2_d.vld  = s1_q.vld;
    s2_d.sub  = sa ^ sbn;
    s2_d.sign = a_max ? sa : sbn;
    s2_d.exp  = mx_e;
    s2_d.mx   = {1'b1, mx_m, 8'h00};
    s2_d.mn   = (d >= 8'd16) ? 16'h0000
                             : ({1'b1, mn_m, 8'h00} >> d);
    unique case (1'b1)
      c_nan, c_ii: begin
        s2_d.spc      = 1'b1;
        s2_d.spc_data = 16'h7FC0;
`ifdef BF16_SUB_FLAGS_EN
        s2_d.inv      = 1'b1;
`endif
      end
      c_ia: begin
        s2_d.spc      = 1'b1;
        s2_d.spc_data = {sa, 8'hFF, 7'h00};
      end
      c_ib: begin
        s2_d.spc      = 1'b1;
        s2_d.spc_data = {sbn, 8'hFF, 7'h00};
      end
      c_zz: begin
        s2_d.spc      = 1'b1;
        s2_d.spc_data = (sa & ~sb) ? 16'h8000 : 16'h0000;
      end
      c_bz: begin
        s2_d.spc      = 1'b1;
        s2_d.spc_data = s1_q.a;
      end
      c_az: begin
        s2_d.spc      = 1'b1;
        s2_d.spc_data = {sbn, s1_q.b[14:0]};
      end
      default: ;
    endcase
  end

  // S2: aligned operands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_q <= '0;
    end else if (adv) begin
      s2_q <= s2_d;
    end
  end

  // ALU: magnitude add or subtract, never negative
  always_comb begin
    s3_d          = '0;
    s3_d.vld      = s2_q.vld;
    s3_d.spc      = s2_q.spc;
    s3_d.spc_data = s2_q.spc_data;
`ifdef BF16_SUB_FLAGS_EN
    s3_d.inv      = s2_q.inv;
`endif
    s3_d.sign     = s2_q.sign;
    s3_d.exp      = s2_q.exp;
    s3_d.sum      = s2_q.sub
                  ? ({1'b0, s2_q.mx} - {1'b0, s2_q.mn})
                  : ({1'b0, s2_q.mx} + {1'b0, s2_q.mn});
  end

  // S3: raw sum
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s3_q <= '0;
    end else if (adv) begin
      s3_q <= s3_d;
    end
  end

  logic [4:0]        lz;
  logic [15:0]       nm;
  logic signed [9:0] e;
  logic [6:0]        frac;
  logic [15:0]       res;
`ifdef BF16_SUB_FLAGS_EN
  logic              of, uf;
`endif

  // Leading-one detect on the low 16 bits of the sum
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (s3_q.sum[i]) lz = 5'(15 - i);
    end
  end

  // Normalize: carry-out shifts right, otherwise shift out leading zeros
  always_comb begin
    nm = '0;
    e  = '0;
    if (s3_q.sum[16]) begin
      nm = s3_q.sum[16:1];
      e  = $signed({2'b00, s3_q.exp}) + 10'sd1;
    end else begin
      nm = s3_q.sum[15:0] << lz;
      e  = $signed({2'b00, s3_q.exp}) - $signed({5'b00000, lz});
    end
  end

  assign frac = 7'(nm >> 8);

  // Pack with overflow to inf and underflow to signed zero
  always_comb begin
    res = '0;
`ifdef BF16_SUB_FLAGS_EN
    of  = 1'b0;
    uf  = 1'b0;
`endif
    if (s3_q.spc) begin
      res = s3_q.spc_data;
    end else if (s3_q.sum == 17'h0) begin
      res = 16'h0000;
    end else if (e >= 10'sd255) begin
      res = {s3_q.sign, 8'hFF, 7'h00};
`ifdef BF16_SUB_FLAGS_EN
      of  = 1'b1;
`endif
    end else if (e <= 10'sd0) begin
      res = {s3_q.sign, 15'h0000};
`ifdef BF16_SUB_FLAGS_EN
      uf  = 1'b1;
`endif
    end else begin
      res = {s3_q.sign, e[7:0], frac};
    end
  end

  // Output register: data only changes when a valid result lands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (adv) begin
      o_valid <= s3_q.vld;
      if (s3_q.vld) o_data <= res;
    end
  end

`ifdef BF16_SUB_FLAGS_EN
  // Flags travel with their result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_flags <= 3'b000;
    end else if (adv && s3_q.vld) begin
      o_flags <= {s3_q.inv, of, uf};
    end
  end
`endif

endmodule

// File: tb/tb_bf16_sub_pipe.sv
// tb_bf16_sub_pipe: vector table, stall/reset sequences and
// randomized streaming against a value-level BF16 subtraction model.

module tb_bf16_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [15:0] da = 16'h0;
  logic [15:0] db = 16'h0;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
`ifdef BF16_SUB_FLAGS_EN
  logic [2:0]  o_flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_rx    = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  f;
  } res_t;

  res_t exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [2:0]  f;
    string       nm;
  } vec_t;

  always #5 clk = ~clk;

  bf16_sub_pipe #(.SIZE_DATA(16)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data_a (da),
    .i_data_b (db),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data)
`ifdef BF16_SUB_FLAGS_EN
    ,
    .o_flags  (o_flags)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Value-level model: classify, align to 16-bit mantissas,
  // add/subtract as integers, locate the MSB, truncate.
  function automatic res_t ref_sub(input logic [15:0] a,
                                   input logic [15:0] b);
    res_t r;
    int ea, eb, ma, mb, ex, sh, mxv, mnv, s, p, e, fr;
    logic sa, sb, sbn, sg, a_big;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = int'(a[6:0]);
    mb = int'(b[6:0]);
    sa = a[15];
    sb = b[15];
    sbn = ~sb;
    r.d = 16'h0000;
    r.f = 3'b000;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) begin
      r.d = 16'h7FC0; r.f = 3'b100; return r;
    end
    if (ea == 255 && eb == 255) begin
      if (sa == sb) begin r.d = 16'h7FC0; r.f = 3'b100; end
      else r.d = {sa, 8'hFF, 7'h00};
      return r;
    end
    if (ea == 255) begin r.d = {sa, 8'hFF, 7'h00}; return r; end
    if (eb == 255) begin r.d = {sbn, 8'hFF, 7'h00}; return r; end
    if (ea == 0 && eb == 0) begin
      r.d = (sa && !sb) ? 16'h8000 : 16'h0000; return r;
    end
    if (eb == 0) begin r.d = a; return r; end
    if (ea == 0) begin r.d = {sbn, b[14:0]}; return r; end
    a_big = (ea > eb) || (ea == eb && ma >= mb);
    ex  = a_big ? ea : eb;
    sh  = ex - (a_big ? eb : ea);
    sg  = a_big ? sa : sbn;
    mxv = (128 + (a_big ? ma : mb)) * 256;
    mnv = (128 + (a_big ? mb : ma)) * 256;
    mnv = (sh >= 16) ? 0 : (mnv >> sh);
    s   = (sa == sbn) ? mxv + mnv : mxv - mnv;
    if (s == 0) return r;
    p = 0;
    while ((s >> (p + 1)) != 0) p++;
    e  = ex + p - 15;
    fr = (p >= 7) ? ((s >> (p - 7)) & 127) : ((s << (7 - p)) & 127);
    if (e >= 255) begin
      r.d = {sg, 8'hFF, 7'h00}; r.f = 3'b010;
    end else if (e <= 0) begin
      r.d = {sg, 15'h0000}; r.f = 3'b001;
    end else begin
      r.d = {sg, 8'(e), 7'(fr)};
    end
    return r;
  endfunction

  // One pair into an idle pipeline with i_ready high; checks latency and data
  task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input string nm);
    int k;
    @(negedge clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
    da = a;
    db = b;
    @(posedge clk);
    #1 i_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_valid && k < 8);
    chk({nm, " latency"}, 32'(k - 1), 32'd3);
    chk({nm, " data"}, {16'h0, o_data}, {16'h0, ed});
  endtask

  // One streaming cycle: drive, then score the handshakes of the next edge
  task automatic step(input logic v, input logic [15:0] a,
                      input logic [15:0] b, input logic r,
                      output logic acc);
    res_t e;
    @(negedge clk);
    i_valid = v;
    da = a;
    db = b;
    i_ready = r;
    #1;
    acc = v && o_ready;
    if (o_valid && r) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream extra: got %h expected none", o_data);
      end else begin
        e = exp_q.pop_front();
        n_rx++;
        chk("stream data", {16'h0, o_data}, {16'h0, e.d});
`ifdef BF16_SUB_FLAGS_EN
        chk("stream flags", {29'h0, o_flags}, {29'h0, e.f});
`endif
      end
    end
    if (acc) exp_q.push_back(ref_sub(a, b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[17];
    logic [15:0] pa[5];
    logic [15:0] pb[5];
    logic [15:0] held;
    logic        acc;
    logic        st;
    logic [15:0] ra, rb;
    int          idx;

    tbl[0]  = '{16'h4040, 16'h3F80, 16'h4000, 3'b000, "3-1"};
    tbl[1]  = '{16'h3F80, 16'h4040, 16'hC000, 3'b000, "1-3"};
    tbl[2]  = '{16'h3F80, 16'h3F80, 16'h0000, 3'b000, "x-x"};
    tbl[3]  = '{16'h3F80, 16'h3B80, 16'h3F7F, 3'b000, "d8trunc"};
    tbl[4]  = '{16'h7F7F, 16'hFF7F, 16'h7F80, 3'b010, "ovf"};
    tbl[5]  = '{16'h7F80, 16'h7F80, 16'h7FC0, 3'b100, "inf-inf"};
    tbl[6]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 3'b100, "nan"};
    tbl[7]  = '{16'hFF80, 16'h7F80, 16'hFF80, 3'b000, "ninf-inf"};
    tbl[8]  = '{16'h3F80, 16'h7F80, 16'hFF80, 3'b000, "x-inf"};
    tbl[9]  = '{16'h8000, 16'h0000, 16'h8000, 3'b000, "n0-p0"};
    tbl[10] = '{16'h0000, 16'h8000, 16'h0000, 3'b000, "p0-n0"};
    tbl[11] = '{16'h4040, 16'h0000, 16'h4040, 3'b000, "x-0"};
    tbl[12] = '{16'h0000, 16'h4040, 16'hC040, 3'b000, "0-x"};
    tbl[13] = '{16'h0080, 16'h00C0, 16'h8000, 3'b001, "unf"};
    tbl[14] = '{16'h3F80, 16'hBF80, 16'h4000, 3'b000, "1-n1"};
    tbl[15] = '{16'h0001, 16'h3F80, 16'hBF80, 3'b000, "ftz"};
    tbl[16] = '{16'h4B80, 16'h3F80, 16'h4B80, 3'b000, "d24"};

    pa = '{16'h4040, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4040};
    pb = '{16'h3F80, 16'h4040, 16'h3F80, 16'h3B80, 16'h0000};

    repeat (3) @(negedge clk);
    chk("reset o_valid", {31'h0, o_valid}, 32'd0);
    chk("reset o_data", {16'h0, o_data}, 32'h0);
    chk("reset o_ready", {31'h0, o_ready}, 32'd1);
`ifdef BF16_SUB_FLAGS_EN
    chk("reset o_flags", {29'h0, o_flags}, 32'h0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].nm);
`ifdef BF16_SUB_FLAGS_EN
      chk({tbl[i].nm, " flags"}, {29'h0, o_flags}, {29'h0, tbl[i].f});
`endif
    end

    // Five pairs with a four-cycle consumer stall once results emerge
    @(negedge clk);
    exp_q.delete();
    n_rx = 0;
    idx = 0;
    held = 16'h0;
    for (int c = 0; c < 30; c++) begin
      st = (c >= 4 && c < 8);
      step(idx < 5, pa[idx < 5 ? idx : 0], pb[idx < 5 ? idx : 0],
           !st, acc);
      if (acc) idx++;
      if (st) begin
        chk("stall o_ready", {31'h0, o_ready}, 32'd0);
        chk("stall o_valid", {31'h0, o_valid}, 32'd1);
        if (c == 4) held = o_data;
        else chk("stall hold", {16'h0, o_data}, {16'h0, held});
      end
    end
    chk("stall count", 32'(n_rx), 32'd5);
    chk("stall leftover", 32'(exp_q.size()), 32'd0);

    // Reset with results in flight
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, pa[c], pb[c], 1'b1, acc);
    end
    @(negedge clk);
    i_valid = 1'b0;
    chk("pre-reset o_valid", {31'h0, o_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset o_valid", {31'h0, o_valid}, 32'd0);
    chk("mid-reset o_data", {16'h0, o_data}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset o_ready", {31'h0, o_ready}, 32'd1);
    run_one(16'h4040, 16'h3F80, 16'h4000, "post-reset");

    // Randomized streaming with random backpressure
    @(negedge clk);
    exp_q.delete();
    n_rx = 0;
    for (int c = 0; c < 400; c++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        rb = {rb[15], ra[14:0] ^ 15'($urandom_range(0, 255))};
      if ($urandom_range(0, 9) == 0) ra[14:7] = 8'hFF;
      if ($urandom_range(0, 9) == 0) rb[14:7] = 8'h00;
      step($urandom_range(0, 9) < 7, ra, rb,
           $urandom_range(0, 9) < 7, acc);
    end
    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() == 0) break;
      step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    end
    chk("drain empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
